// File: rtl/regfile_pkg.sv
// Shared types for the register-file command sequencer: data/address width defaults,
// opcode and sequencer state encodings.
package regfile_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

    typedef enum logic [1:0] {
        OP_LDI = 2'b00,
        OP_MOV = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_EXEC  = 2'b10,
        S_WRITE = 2'b11
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; grant is combinational from req, same cycle.
// A tie goes to the channel not granted last; last_grant moves only on advance.
module rr_arbiter2 (
    input  logic       CLK,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Reset value 1 makes channel 0 win the first tie.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Arbitrates two command channels onto the 4x8 register file; 4 cycles per command (rsp 3 after accept).
// cmd_ready only in IDLE, so a requester is stalled for the whole READ/EXEC/WRITE sequence.
module regfile_sequencer
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [1:0]          cmd_valid,
    output logic [1:0]          cmd_ready,
    input  logic [3:0]          cmd_op,
    input  logic [2*ADDR_W-1:0] cmd_rd,
    input  logic [2*ADDR_W-1:0] cmd_rs1,
    input  logic [2*ADDR_W-1:0] cmd_rs2,
    input  logic [2*DATA_W-1:0] cmd_imm,
    output logic                rsp_valid,
    output logic                rsp_ch,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_flag,
    output logic [ADDR_W-1:0]   rf_ra1,
    output logic [ADDR_W-1:0]   rf_ra2,
    input  logic [DATA_W-1:0]   rf_rd1,
    input  logic [DATA_W-1:0]   rf_rd2,
    output logic [ADDR_W-1:0]   rf_ra3,
    output logic [DATA_W-1:0]   rf_wd3,
    output logic                rf_we3
);

    typedef struct packed {
        logic              ch;
        op_e               op;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [DATA_W-1:0] imm;
    } cmd_t;

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_sel;
    logic [DATA_W-1:0] op1_q, op2_q;
    logic [DATA_W-1:0] res_q, res_d;
    logic              flag_q, flag_d;
    logic [DATA_W:0]   sum, diff;
    logic [1:0]        arb_req;
    logic [1:0]        grant;
    logic              hs;

    // Requests are masked outside IDLE so cmd_ready is zero while a command is in flight.
    assign arb_req   = (state_q == S_IDLE) ? cmd_valid : 2'b00;
    assign cmd_ready = grant;
    assign hs        = |(cmd_valid & grant);

    rr_arbiter2 u_arb (
        .CLK     (CLK),
        .reset   (reset),
        .req     (arb_req),
        .advance (hs),
        .grant   (grant)
    );

    always_comb begin
        cmd_sel    = '0;
        cmd_sel.ch = grant[1];
        if (grant[1]) begin
            cmd_sel.op  = op_e'(cmd_op[3:2]);
            cmd_sel.rd  = cmd_rd[2*ADDR_W-1:ADDR_W];
            cmd_sel.rs1 = cmd_rs1[2*ADDR_W-1:ADDR_W];
            cmd_sel.rs2 = cmd_rs2[2*ADDR_W-1:ADDR_W];
            cmd_sel.imm = cmd_imm[2*DATA_W-1:DATA_W];
        end else begin
            cmd_sel.op  = op_e'(cmd_op[1:0]);
            cmd_sel.rd  = cmd_rd[ADDR_W-1:0];
            cmd_sel.rs1 = cmd_rs1[ADDR_W-1:0];
            cmd_sel.rs2 = cmd_rs2[ADDR_W-1:0];
            cmd_sel.imm = cmd_imm[DATA_W-1:0];
        end
    end

    // The MSB of the widened subtraction is the unsigned borrow.
    assign sum  = {1'b0, op1_q} + {1'b0, op2_q};
    assign diff = {1'b0, op1_q} - {1'b0, op2_q};

    always_comb begin
        res_d  = '0;
        flag_d = 1'b0;
        case (cmd_q.op)
            OP_LDI:  res_d = cmd_q.imm;
            OP_MOV:  res_d = op1_q;
            OP_ADD:  {flag_d, res_d} = sum;
            OP_SUB:  {flag_d, res_d} = diff;
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                cmd_q <= cmd_sel;
            end
            // Operands are captured before the write, so rd == rs uses the old value.
            if (state_q == S_READ) begin
                op1_q <= rf_rd1;
                op2_q <= rf_rd2;
            end
            if (state_q == S_EXEC) begin
                res_q  <= res_d;
                flag_q <= flag_d;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rf_ra1    = '0;
        rf_ra2    = '0;
        rf_ra3    = '0;
        rf_wd3    = '0;
        rf_we3    = 1'b1;
        rsp_valid = 1'b0;
        rsp_ch    = 1'b0;
        rsp_data  = '0;
        rsp_flag  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rf_ra1  = cmd_q.rs1;
                rf_ra2  = cmd_q.rs2;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                rf_we3    = 1'b0;
                rf_ra3    = cmd_q.rd;
                rf_wd3    = res_q;
                rsp_valid = 1'b1;
                rsp_ch    = cmd_q.ch;
                rsp_data  = res_q;
                rsp_flag  = flag_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomised + directed bench for regfile_sequencer with a register-file model and
// an issue-time reference model feeding a response scoreboard.
module tb_regfile_sequencer;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cmd_valid = 2'b00;
    logic [1:0]  cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [3:0]  cmd_rd = '0;
    logic [3:0]  cmd_rs1 = '0;
    logic [3:0]  cmd_rs2 = '0;
    logic [15:0] cmd_imm = '0;
    logic        rsp_valid;
    logic        rsp_ch;
    logic [7:0]  rsp_data;
    logic        rsp_flag;
    logic [1:0]  rf_ra1, rf_ra2, rf_ra3;
    logic [7:0]  rf_rd1, rf_rd2, rf_wd3;
    logic        rf_we3;

    regfile_sequencer dut (
        .CLK       (CLK),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_imm   (cmd_imm),
        .rsp_valid (rsp_valid),
        .rsp_ch    (rsp_ch),
        .rsp_data  (rsp_data),
        .rsp_flag  (rsp_flag),
        .rf_ra1    (rf_ra1),
        .rf_ra2    (rf_ra2),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .rf_ra3    (rf_ra3),
        .rf_wd3    (rf_wd3),
        .rf_we3    (rf_we3)
    );

    always #5 CLK = ~CLK;

    // Register file: combinational reads, write on rising edge with active-low enable.
    logic [7:0] rf [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    assign rf_rd1 = rf[rf_ra1];
    assign rf_rd2 = rf[rf_ra2];
    always @(posedge CLK) if (rf_we3 == 1'b0) rf[rf_ra3] <= rf_wd3;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { int op; int rd; int rs1; int rs2; int imm; bit abort; } tcmd_t;
    typedef struct { int ch; int data; int flag; int rd; int cyc; } exp_t;

    tcmd_t q0[$], q1[$];
    tcmd_t cur[2];
    bit    busy[2];
    exp_t  sb[$];
    int    gseq[$];
    int    rsp_times[$];
    int    mreg[4] = '{0, 0, 0, 0};
    int    last_ch = 1;
    bit    gaps = 0;
    bit    mon_en = 0;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per completion pulse.
    always @(negedge CLK) begin
        if (mon_en) begin
            chk("we3_only_with_rsp", rf_we3, !rsp_valid);
            chk("ready_not_both", cmd_ready == 2'b11, 1'b0);
            if (rsp_valid === 1'b1) begin
                rsp_times.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_valid with no outstanding command, data 0x%0h at cycle %0d", rsp_data, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_ch", rsp_ch, e.ch);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_flag", rsp_flag, e.flag);
                    chk("rf_ra3", rf_ra3, e.rd);
                    chk("rf_wd3", rf_wd3, e.data);
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Reference: command semantics on an integer register array, evaluated at accept time.
    task automatic issue_model(input int ch, input int ecyc);
        tcmd_t c;
        exp_t  e;
        int    a, b;
        c = cur[ch];
        a = mreg[c.rs1];
        b = mreg[c.rs2];
        e.ch = ch; e.rd = c.rd; e.cyc = ecyc; e.flag = 0;
        case (c.op)
            0: e.data = c.imm;
            1: e.data = a;
            2: begin e.data = (a + b) % 256; e.flag = (a + b > 255) ? 1 : 0; end
            default: begin e.data = (a - b + 256) % 256; e.flag = (a < b) ? 1 : 0; end
        endcase
        mreg[c.rd] = e.data;
        sb.push_back(e);
    endtask

    task automatic apply();
        cmd_valid = {busy[1], busy[0]};
        for (int c = 0; c < 2; c++) begin
            logic [31:0] v;
            v = cur[c].op;  cmd_op[c*2 +: 2]  = v[1:0];
            v = cur[c].rd;  cmd_rd[c*2 +: 2]  = v[1:0];
            v = cur[c].rs1; cmd_rs1[c*2 +: 2] = v[1:0];
            v = cur[c].rs2; cmd_rs2[c*2 +: 2] = v[1:0];
            v = cur[c].imm; cmd_imm[c*8 +: 8] = v[7:0];
        end
    endtask

    // Called at the negedge before the accepting edge; resets the DUT during EXEC.
    task automatic do_abort(input int ch);
        busy[ch] = 0;
        @(negedge CLK);
        apply();
        @(negedge CLK);
        reset = 1'b0;
        #1;
        chk("abort_we3_idle", rf_we3, 1'b1);
        chk("abort_no_rsp", rsp_valid, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        last_ch = 1;
    endtask

    task automatic run(input int budget);
        int n;
        bit skip, post;
        n = 0; skip = 0; post = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy[0] || busy[1]) && n < budget) begin
            if (!skip) @(negedge CLK);
            skip = 0;
            if (!busy[0] && q0.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                cur[0] = q0.pop_front(); busy[0] = 1;
            end
            if (!busy[1] && q1.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                cur[1] = q1.pop_front(); busy[1] = 1;
            end
            apply();
            #1;
            if (post) begin
                chk("ready_after_reset", cmd_ready != 2'b00, busy[0] | busy[1]);
                post = 0;
            end
            if (cmd_ready == 2'b01 || cmd_ready == 2'b10) begin
                int g, eg;
                g  = cmd_ready[1] ? 1 : 0;
                eg = (busy[0] && busy[1]) ? 1 - last_ch : (busy[1] ? 1 : 0);
                chk("grant_ch", g, eg);
                chk("grant_of_valid", busy[g], 1'b1);
                if (busy[g]) begin
                    last_ch = g;
                    gseq.push_back(g);
                    if (cur[g].abort) begin
                        do_abort(g);
                        skip = 1;
                        post = 1;
                    end else begin
                        issue_model(g, cyc + 3);
                        busy[g] = 0;
                    end
                end
            end
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL run_budget: %0d cycles used, commands still pending", n);
            q0.delete(); q1.delete(); busy[0] = 0; busy[1] = 0;
        end
        @(negedge CLK);
        apply();
        n = 0;
        while (sb.size() != 0 && n < 12) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
            sb.delete();
        end
        @(negedge CLK);
    endtask

    function automatic tcmd_t mk(input int op, input int rd, input int rs1, input int rs2, input int imm);
        tcmd_t c;
        c.op = op; c.rd = rd; c.rs1 = rs1; c.rs2 = rs2; c.imm = imm; c.abort = 0;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tcmd_t a;
        #1 reset = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_we3", rf_we3, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 2'b00);
        chk("rst_rf_addrs", {rf_ra1, rf_ra2, rf_ra3}, 6'd0);
        chk("rst_rf_wd3", rf_wd3, 8'h00);
        chk("rst_rsp_fields", {rsp_ch, rsp_data, rsp_flag}, 10'd0);
        reset = 1'b1;
        mon_en = 1;

        // Both channels continuously valid: strict alternation from ch0.
        gseq.delete();
        q0.push_back(mk(0, 1, 0, 0, 8'hF0));
        q0.push_back(mk(0, 3, 0, 0, 8'h55));
        q1.push_back(mk(0, 2, 0, 0, 8'h20));
        q1.push_back(mk(2, 0, 1, 2, 0));
        run(100);
        chk("fair_count", gseq.size(), 4);
        for (int i = 0; i < 4 && i < gseq.size(); i++) chk("fair_order", gseq[i], i % 2);

        // Reset during EXEC of ADD r3 on ch0 while ch1 waits.
        a = mk(2, 3, 1, 2, 0);
        a.abort = 1;
        q0.push_back(a);
        q1.push_back(mk(0, 2, 0, 0, 8'h20));
        run(100);
        chk("abort_r3_kept", rf[3], mreg[3]);

        // Back-to-back single-channel commands, accepted every 4 cycles.
        rsp_times.delete();
        q0.push_back(mk(0, 1, 0, 0, 8'h03));
        q0.push_back(mk(1, 2, 1, 0, 0));
        run(100);
        chk("b2b_rsp_count", rsp_times.size(), 2);
        if (rsp_times.size() == 2) chk("b2b_spacing", rsp_times[1] - rsp_times[0], 4);

        q0.push_back(mk(0, 1, 0, 0, 8'hF0));
        q0.push_back(mk(0, 2, 0, 0, 8'h20));
        q0.push_back(mk(2, 3, 1, 2, 0));
        q0.push_back(mk(3, 0, 3, 2, 0));
        q0.push_back(mk(3, 0, 1, 2, 0));
        q0.push_back(mk(0, 1, 0, 0, 8'h81));
        q0.push_back(mk(2, 1, 1, 1, 0));
        q0.push_back(mk(1, 0, 1, 0, 0));
        run(200);

        // Random traffic on both channels with random gaps.
        gaps = 1;
        for (int i = 0; i < 60; i++) begin
            tcmd_t c;
            c = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) q0.push_back(c); else q1.push_back(c);
        end
        run(2000);
        gaps = 0;

        for (int i = 0; i < 4; i++) chk("final_reg", rf[i], mreg[i]);

        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
